alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream feeder for the 32-bit ALU: accepts one ALU command at a time over a valid/ready handshake and drives the ALU A/B/FunSel/WF inputs.
//  Repeats single-bit shift/rotate codes to build multi-bit shifts.
//  Captures ALUOut and the registered {Z,C,N,O} flags, then presents both as one result over a valid/ready handshake.
//  This is the only block allowed to assert the ALU's WF input.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must equal the ALU width (only 32 supported)
//  CNT_WIDTH   5   width of the shift repeat count
// PORTS
//  Clock        in   1   system clock; all state changes on posedge
//  Reset        in   1   asynchronous, active-low reset
//  CmdValid     in   1   command present
//  CmdReady     out  1   sequencer can accept a command (high only in IDLE)
//  CmdFunSel    in   5   ALU function: [4] width select, [3:0] operation code
//  CmdA         in   32  operand A
//  CmdB         in   32  operand B
//  CmdCount     in   5   shift repeat count; used only for codes 1011..1111
//  CmdSetFlags  in   1   1 = update ALU flags on every ALU pass of this command
//  AluA         out  32  to ALU A
//  AluB         out  32  to ALU B
//  AluFunSel    out  5   to ALU FunSel
//  AluWF        out  1   to ALU WF
//  AluOut       in   32  from ALU ALUOut (combinational in A/B/FunSel)
//  AluFlags     in   4   from ALU FlagsOut {Z,C,N,O}; updated at the edge where WF=1
//  ResValid     out  1   result available
//  ResReady     in   1   consumer takes result
//  ResData      out  32  captured ALU result
//  ResFlags     out  4   captured {Z,C,N,O} after the last pass
// BEHAVIOUR
//  Reset (Reset=0, async)
//   - State = IDLE; OpA/OpB/Fun/Rem/ResData/ResFlags/SetF = 0.
//   - Outputs: CmdReady=1, ResValid=0, AluWF=0.
//   - Reset mid-command aborts it: no ResValid. ALU flags are not reset by this block.
//  FSM states: IDLE, EXEC, CAPT, DONE
//  IDLE
//   - CmdReady=1.
//   - On CmdValid&CmdReady: latch CmdA->OpA, CmdB->OpB, CmdFunSel->Fun, CmdSetFlags->SetF.
//   - Rem = shift ? max(CmdCount,1) : 1, where shift means Fun[3:0] >= 4'b1011.
//   - Go to EXEC.
//  EXEC
//   - Drive AluA=OpA, AluB=OpB, AluFunSel=Fun, AluWF=SetF.
//   - Each edge: ResData<=AluOut, OpA<=AluOut, Rem<=Rem-1.
//   - If Rem==1, go to CAPT; else stay in EXEC.
//   - So shifts chain; CSL/CSR chain through C when SetF=1.
//  CAPT
//   - AluWF=0; ResFlags<=AluFlags (flags now reflect the last pass); go to DONE.
//  DONE
//   - ResValid=1; ResData/ResFlags held stable; AluWF=0; CmdReady=0.
//   - On ResReady, go to IDLE.
//   - A new command is accepted no earlier than the cycle after the result handshake (no overlap).
//  Outside EXEC
//   - AluWF=0; AluA/AluB/AluFunSel keep their last latched values.
//  Latency
//   - Accept edge to ResValid high = N+1 cycles, where N is the number of passes (non-shift: N=1, so 2 cycles).
//   - Maximum N = 31.
//  Other rules
//   - CmdCount is ignored for non-shift codes; CmdCount=0 on a shift means 1 pass.
//   - Command inputs are sampled only at accept; changes afterwards have no effect.
//   - SetF=0: WF is never asserted; ResFlags = the ALU flags unchanged from before the command.
// TESTING
//  1. Assert Reset low during pass 3 of a 6-pass LSL -> immediately: ResValid=0, CmdReady=1, AluWF=0; after release, no stale result appears.
//  2. FunSel=5'b10100, A=32'hFFFFFFFF, B=1, SetFlags=1 -> AluWF high exactly 1 cycle; ResValid 2 cycles after accept; ResData=0; ResFlags[3]=1.
//  3. FunSel=5'b01011 (LSL), A=1, Count=4, SetFlags=1 -> AluWF high 4 consecutive cycles; ResValid 5 cycles after accept; ResData=32'h10.
//  4. Hold ResReady=0 for 10 cycles in DONE -> ResValid, ResData, ResFlags stable; CmdReady=0; AluWF=0 throughout.
//  5. FunSel=5'b00111 (AND), SetFlags=0, after an op that left flags=4'b1000 -> AluWF never high; ResFlags=4'b1000.
//  6. CmdValid held high with two queued commands and ResReady=1 -> second accepted in the IDLE cycle after the first result handshake; both results correct and in order.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the 32-bit ALU: takes one command at a time, drives
// the ALU for one or more passes, and hands back the captured result and flags.
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic [4:0]            CmdFunSel,
    input  logic [DATA_WIDTH-1:0] CmdA,
    input  logic [DATA_WIDTH-1:0] CmdB,
    input  logic [CNT_WIDTH-1:0]  CmdCount,
    input  logic                  CmdSetFlags,
    output logic [DATA_WIDTH-1:0] AluA,
    output logic [DATA_WIDTH-1:0] AluB,
    output logic [4:0]            AluFunSel,
    output logic                  AluWF,
    input  logic [DATA_WIDTH-1:0] AluOut,
    input  logic [3:0]            AluFlags,
    output logic                  ResValid,
    input  logic                  ResReady,
    output logic [DATA_WIDTH-1:0] ResData,
    output logic [3:0]            ResFlags
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            fun;
    logic [CNT_WIDTH-1:0]  rem;
    logic                  set_f;
    logic                  is_shift;
    logic [CNT_WIDTH-1:0]  start_rem;

    // Codes 1011..1111 are single-bit shifts/rotates; a count of 0 still runs one pass.
    always_comb begin
        is_shift  = (CmdFunSel[3:0] >= 4'b1011);
        start_rem = CNT_WIDTH'(1);
        if (is_shift && (CmdCount != '0)) begin
            start_rem = CmdCount;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            fun      <= '0;
            rem      <= '0;
            set_f    <= 1'b0;
            ResData  <= '0;
            ResFlags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CmdValid) begin
                        op_a  <= CmdA;
                        op_b  <= CmdB;
                        fun   <= CmdFunSel;
                        set_f <= CmdSetFlags;
                        rem   <= start_rem;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Feeding the result back into A lets single-bit shifts chain.
                    ResData <= AluOut;
                    op_a    <= AluOut;
                    rem     <= rem - 1'b1;
                    if (rem == CNT_WIDTH'(1)) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    ResFlags <= AluFlags;
                    state    <= DONE;
                end
                DONE: begin
                    if (ResReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        AluA      = op_a;
        AluB      = op_b;
        AluFunSel = fun;
        AluWF     = (state == EXEC) && set_f;
        CmdReady  = (state == IDLE);
        ResValid  = (state == DONE);
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU (ADD/AND/LSL)
// whose flag register updates on edges where WF is high.
module tb_alu_op_sequencer;

    logic        Clock;
    logic        Reset;
    logic        CmdValid;
    logic        CmdReady;
    logic [4:0]  CmdFunSel;
    logic [31:0] CmdA;
    logic [31:0] CmdB;
    logic [4:0]  CmdCount;
    logic        CmdSetFlags;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;
    logic        ResValid;
    logic        ResReady;
    logic [31:0] ResData;
    logic [3:0]  ResFlags;

    int tests_run;
    int tests_failed;

    alu_op_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .Clock(Clock), .Reset(Reset),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdFunSel(CmdFunSel),
        .CmdA(CmdA), .CmdB(CmdB), .CmdCount(CmdCount), .CmdSetFlags(CmdSetFlags),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags),
        .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData), .ResFlags(ResFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural ALU: C and O keep their old value for operations that do not define them.
    logic [32:0] m_sum;
    logic [31:0] m_out;
    logic        m_c;
    logic        m_o;
    logic [3:0]  alu_flags = 4'b0000;

    always_comb begin
        m_sum = '0;
        m_out = AluA;
        m_c   = alu_flags[2];
        m_o   = alu_flags[0];
        case (AluFunSel[3:0])
            4'b0100: begin
                m_sum = {1'b0, AluA} + {1'b0, AluB};
                m_out = m_sum[31:0];
                m_c   = m_sum[32];
                m_o   = (AluA[31] == AluB[31]) && (m_sum[31] != AluA[31]);
            end
            4'b0111: m_out = AluA & AluB;
            4'b1011: begin
                m_out = {AluA[30:0], 1'b0};
                m_c   = AluA[31];
            end
            default: ;
        endcase
    end

    assign AluOut   = m_out;
    assign AluFlags = alu_flags;

    always @(posedge Clock) begin
        if (AluWF) alu_flags <= {(m_out == 32'h0), m_c, m_out[31], m_o};
    end

    // Issues one command and waits for ResValid; lat counts edges from accept to ResValid.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c, input logic s,
                         output int lat, output int wf_n, output bit wf_contig);
        int  t;
        bit  seen_off;
        CmdFunSel = f; CmdA = a; CmdB = b; CmdCount = c; CmdSetFlags = s; CmdValid = 1'b1;
        t = 0;
        while (!CmdReady && t < 50) begin
            @(posedge Clock); #1; t++;
        end
        @(posedge Clock); #1;
        CmdValid = 1'b0; CmdA = ~a; CmdB = ~b; CmdCount = ~c; CmdFunSel = ~f; CmdSetFlags = ~s;
        lat = 0; wf_n = 0; wf_contig = 1'b1; seen_off = 1'b0;
        while (!ResValid && lat < 60) begin
            if (AluWF) begin
                wf_n++;
                if (seen_off) wf_contig = 1'b0;
            end else if (wf_n > 0) begin
                seen_off = 1'b1;
            end
            @(posedge Clock); #1; lat++;
        end
    endtask

    task automatic take_result();
        ResReady = 1'b1;
        @(posedge Clock); #1;
        ResReady = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (CmdReady !== 1'b1 || ResValid !== 1'b0 || AluWF !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: CmdReady=%b ResValid=%b AluWF=%b, required 1 0 0", CmdReady, ResValid, AluWF);
        end
        tests_run++;
        if (ResData !== 32'h0 || ResFlags !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_res: ResData=%h ResFlags=%b, required 0 0", ResData, ResFlags);
        end
        tests_run++;
        if (AluA !== 32'h0 || AluB !== 32'h0 || AluFunSel !== 5'h0) begin
            tests_failed++;
            $display("FAIL reset_alu: A=%h B=%h Fun=%b, required zeros", AluA, AluB, AluFunSel);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        CmdFunSel = 5'b01011; CmdA = 32'h1; CmdB = 32'h0; CmdCount = 5'd6; CmdSetFlags = 1'b1; CmdValid = 1'b1;
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        tests_run++;
        if (AluWF !== 1'b1 || AluA !== 32'h4) begin
            tests_failed++;
            $display("FAIL mid_pass3: AluWF=%b AluA=%h, required 1 00000004", AluWF, AluA);
        end
        #2 Reset = 1'b0;
        #1;
        tests_run++;
        if (ResValid !== 1'b0 || CmdReady !== 1'b1 || AluWF !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: ResValid=%b CmdReady=%b AluWF=%b, required 0 1 0", ResValid, CmdReady, AluWF);
        end
        @(posedge Clock); #3 Reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock); #1;
            if (ResValid !== 1'b0 || CmdReady !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0 || ResData !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_stale: bad_cycles=%0d ResData=%h, required 0 00000000", bad, ResData);
        end
    endtask

    task automatic test_add32();
        int lat, wf_n; bit wf_c;
        issue(5'b10100, 32'hFFFF_FFFF, 32'h1, 5'd9, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (lat != 2) begin
            tests_failed++; $display("FAIL add_latency: got %0d, required 2", lat);
        end
        tests_run++;
        if (wf_n != 1) begin
            tests_failed++; $display("FAIL add_wf: got %0d cycles, required 1", wf_n);
        end
        tests_run++;
        if (ResData !== 32'h0) begin
            tests_failed++; $display("FAIL add_data: got %h, required 00000000", ResData);
        end
        tests_run++;
        if (ResFlags !== 4'b1100) begin
            tests_failed++; $display("FAIL add_flags: got %b, required 1100", ResFlags);
        end
        take_result();
    endtask

    task automatic test_lsl_multi();
        int lat, wf_n; bit wf_c;
        issue(5'b01011, 32'h1, 32'h0, 5'd4, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (lat != 5) begin
            tests_failed++; $display("FAIL lsl_latency: got %0d, required 5", lat);
        end
        tests_run++;
        if (wf_n != 4 || !wf_c) begin
            tests_failed++; $display("FAIL lsl_wf: got %0d cycles contiguous=%0d, required 4 1", wf_n, wf_c);
        end
        tests_run++;
        if (ResData !== 32'h10 || ResFlags !== 4'b0000) begin
            tests_failed++; $display("FAIL lsl_result: got %h/%b, required 00000010/0000", ResData, ResFlags);
        end
        take_result();
        issue(5'b01011, 32'h4000_0003, 32'h0, 5'd2, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (lat != 3 || ResData !== 32'hC || ResFlags !== 4'b0100) begin
            tests_failed++; $display("FAIL lsl_carry: got lat=%0d %h/%b, required 3 0000000c/0100", lat, ResData, ResFlags);
        end
        take_result();
    endtask

    task automatic test_hold();
        int lat, wf_n, bad; bit wf_c;
        issue(5'b10100, 32'd5, 32'd7, 5'd0, 1'b1, lat, wf_n, wf_c);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ResValid !== 1'b1 || ResData !== 32'd12 || ResFlags !== 4'b0000 ||
                CmdReady !== 1'b0 || AluWF !== 1'b0) bad++;
            @(posedge Clock); #1;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL hold_stable: %0d bad cycles, required 0", bad);
        end
        take_result();
        tests_run++;
        if (ResValid !== 1'b0 || CmdReady !== 1'b1) begin
            tests_failed++; $display("FAIL hold_release: ResValid=%b CmdReady=%b, required 0 1", ResValid, CmdReady);
        end
    endtask

    task automatic test_count_edges();
        int lat, wf_n; bit wf_c;
        issue(5'b01011, 32'h5, 32'h0, 5'd0, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (lat != 2 || wf_n != 1 || ResData !== 32'hA) begin
            tests_failed++; $display("FAIL count_zero: got lat=%0d wf=%0d data=%h, required 2 1 0000000a", lat, wf_n, ResData);
        end
        take_result();
        issue(5'b00111, 32'hF0F0, 32'hFF00, 5'd31, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (lat != 2 || wf_n != 1 || ResData !== 32'hF000) begin
            tests_failed++; $display("FAIL count_ignored: got lat=%0d wf=%0d data=%h, required 2 1 0000f000", lat, wf_n, ResData);
        end
        take_result();
        issue(5'b01011, 32'h1, 32'h0, 5'd31, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (lat != 32 || wf_n != 31 || ResData !== 32'h8000_0000) begin
            tests_failed++; $display("FAIL count_max: got lat=%0d wf=%0d data=%h, required 32 31 80000000", lat, wf_n, ResData);
        end
        take_result();
    endtask

    task automatic test_no_flags();
        int lat, wf_n; bit wf_c;
        issue(5'b10100, 32'h0, 32'h0, 5'd0, 1'b1, lat, wf_n, wf_c);
        tests_run++;
        if (ResFlags !== 4'b1000) begin
            tests_failed++; $display("FAIL noflag_setup: got %b, required 1000", ResFlags);
        end
        take_result();
        issue(5'b00111, 32'hF0, 32'hFF, 5'd0, 1'b0, lat, wf_n, wf_c);
        tests_run++;
        if (wf_n != 0) begin
            tests_failed++; $display("FAIL noflag_wf: got %0d cycles, required 0", wf_n);
        end
        tests_run++;
        if (ResData !== 32'hF0 || ResFlags !== 4'b1000) begin
            tests_failed++; $display("FAIL noflag_result: got %h/%b, required 000000f0/1000", ResData, ResFlags);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        int acc[2]; int hs[2]; logic [31:0] rd[2]; logic [3:0] rf[2];
        int na, nh; bit cr, rv; logic [31:0] d; logic [3:0] fl;
        na = 0; nh = 0;
        acc[0] = -1; acc[1] = -1; hs[0] = -1; hs[1] = -1;
        rd[0] = '0; rd[1] = '0; rf[0] = '0; rf[1] = '0;
        ResReady = 1'b1;
        CmdFunSel = 5'b10100; CmdA = 32'd3; CmdB = 32'd4; CmdCount = 5'd7; CmdSetFlags = 1'b1; CmdValid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cr = CmdReady && CmdValid; rv = ResValid; d = ResData; fl = ResFlags;
            @(posedge Clock); #1;
            if (cr) begin
                if (na < 2) acc[na] = k;
                na++;
                if (na == 1) begin
                    CmdFunSel = 5'b01011; CmdA = 32'h4000_0003; CmdB = 32'h0; CmdCount = 5'd2;
                end else begin
                    CmdValid = 1'b0;
                end
            end
            if (rv) begin
                if (nh < 2) begin hs[nh] = k; rd[nh] = d; rf[nh] = fl; end
                nh++;
            end
            if (nh >= 2) break;
        end
        ResReady = 1'b0; CmdValid = 1'b0;
        tests_run++;
        if (na != 2 || nh != 2) begin
            tests_failed++; $display("FAIL b2b_count: accepts=%0d results=%0d, required 2 2", na, nh);
        end
        tests_run++;
        if (acc[1] != hs[0] + 1) begin
            tests_failed++; $display("FAIL b2b_timing: second accept at %0d, required %0d", acc[1], hs[0] + 1);
        end
        tests_run++;
        if (rd[0] !== 32'd7 || rf[0] !== 4'b0000) begin
            tests_failed++; $display("FAIL b2b_first: got %h/%b, required 00000007/0000", rd[0], rf[0]);
        end
        tests_run++;
        if (rd[1] !== 32'hC || rf[1] !== 4'b0100) begin
            tests_failed++; $display("FAIL b2b_second: got %h/%b, required 0000000c/0100", rd[1], rf[1]);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        Reset = 1'b0; CmdValid = 1'b0; ResReady = 1'b0;
        CmdFunSel = '0; CmdA = '0; CmdB = '0; CmdCount = '0; CmdSetFlags = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        test_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        test_reset_mid();
        test_add32();
        test_lsl_multi();
        test_hold();
        test_count_edges();
        test_no_flags();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
